// File: rtl/cdp1802_pkg.sv
// Shared definitions for the CDP1802 DMA/interrupt responder: bus state codes,
// controller state encoding and default machine-cycle timing.
package cdp1802_pkg;

    localparam int CYCLE_LEN_DEF = 8;
    localparam int DATA_TICK_DEF = 5;

    localparam logic [1:0] SC_FETCH = 2'b00;
    localparam logic [1:0] SC_EXEC  = 2'b01;
    localparam logic [1:0] SC_DMA   = 2'b10;
    localparam logic [1:0] SC_INT   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DMA,
        ST_IRQ,
        ST_DMAI
    } state_t;

endpackage

// File: rtl/cdp1802_cycle_timer.sv
// Machine-cycle tick counter: counts clk_enable ticks 0..CYCLE_LEN-1 and flags
// the first tick, the last tick (cycle end) and the data-latch tick.
module cdp1802_cycle_timer #(
    parameter int CYCLE_LEN = 8,
    parameter int DATA_TICK = 5,
    parameter int TW        = $clog2(CYCLE_LEN)
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    output logic cycle_start,
    output logic cycle_end,
    output logic data_tick
);

    logic [TW-1:0] tcnt;
    logic          last_tick;

    assign last_tick   = (tcnt == TW'(CYCLE_LEN - 1));
    assign cycle_start = clk_enable && (tcnt == '0);
    assign cycle_end   = clk_enable && last_tick;
    assign data_tick   = clk_enable && (tcnt == TW'(DATA_TICK));

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (clk_enable) begin
            tcnt <= last_tick ? '0 : tcnt + TW'(1);
        end
    end

endmodule

// File: rtl/cdp1802_dma_ctrl.sv
// CDP1802 bus-side arbiter for S0/S1 core cycles, S2 DMA-out and S3 interrupt
// cycles. Optional DMA-in support is compiled in with CDP1802_DMA_IN_EN.
module cdp1802_dma_ctrl
    import cdp1802_pkg::*;
#(
    parameter int CYCLE_LEN = CYCLE_LEN_DEF,
    parameter int DATA_TICK = DATA_TICK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [1:0]  core_sc,
    output logic        core_hold,
    input  logic        DMAO,
    input  logic        INT,
    output logic        ie,
    input  logic        ie_set,
    input  logic        ie_clr,
    input  logic        r0_wr,
    input  logic [15:0] r0_wdata,
    output logic [15:0] r0,
    output logic [1:0]  SC,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [7:0]  data_out,
    output logic        int_taken
`ifdef CDP1802_DMA_IN_EN
    ,
    input  logic        DMAI,
    input  logic [7:0]  dma_in_data,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata
`endif
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  sc_nxt;
    logic [15:0] r0_nxt;
    logic        ie_nxt;
    logic        cycle_start;
    logic        cycle_end;
    logic        data_tick;
    logic        dma_in_req;
    logic        in_dma;
    logic        from_fetch;

    cdp1802_cycle_timer #(
        .CYCLE_LEN (CYCLE_LEN),
        .DATA_TICK (DATA_TICK)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .cycle_start (cycle_start),
        .cycle_end   (cycle_end),
        .data_tick   (data_tick)
    );

`ifdef CDP1802_DMA_IN_EN
    assign dma_in_req = DMAI;
    assign mem_wr     = (state == ST_DMAI) && data_tick;
    assign mem_wdata  = dma_in_data;
`else
    assign dma_in_req = 1'b0;
`endif

    assign in_dma     = (state == ST_DMA) || (state == ST_DMAI);
    assign from_fetch = (state == ST_RUN) && (SC == SC_FETCH);
    assign core_hold  = (state != ST_RUN);
    assign int_taken  = (state == ST_IRQ) && cycle_start;

    // Arbitration result, consumed only on the cycle-end tick.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_nxt = ST_RUN;
        sc_nxt    = core_sc;
        if (!from_fetch) begin
            if (dma_in_req) begin
                state_nxt = ST_DMAI;
                sc_nxt    = SC_DMA;
            end else if (DMAO) begin
                state_nxt = ST_DMA;
                sc_nxt    = SC_DMA;
            end else if (INT && ie && state != ST_IRQ) begin
                state_nxt = ST_IRQ;
                sc_nxt    = SC_INT;
            end else if (state == ST_IRQ) begin
                sc_nxt    = SC_FETCH;
            end
        end
    end

    // A core write can land on the same tick as a boundary into DMA, so the
    // next DMA address is taken from r0_nxt rather than r0.
    always_comb begin
        r0_nxt = r0;
        if (cycle_end && in_dma) begin
            r0_nxt = r0 + 16'd1;
        end else if (clk_enable && r0_wr && state == ST_RUN) begin
            r0_nxt = r0_wdata;
        end
    end

    always_comb begin
        ie_nxt = ie;
        if (clk_enable) begin
            if (ie_clr || int_taken) begin
                ie_nxt = 1'b0;
            end else if (ie_set) begin
                ie_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            SC       <= SC_FETCH;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else if (cycle_end) begin
            state    <= state_nxt;
            SC       <= sc_nxt;
            mem_rd   <= (state_nxt == ST_DMA);
            mem_addr <= (state_nxt == ST_DMA || state_nxt == ST_DMAI) ? r0_nxt : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0 <= '0;
            ie <= 1'b1;
        end else begin
            r0 <= r0_nxt;
            ie <= ie_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (data_tick && state == ST_DMA) begin
            data_out <= mem_data;
        end
    end

endmodule

// File: tb/tb_cdp1802_dma_ctrl.sv
// Scoreboard bench for cdp1802_dma_ctrl: a per-machine-cycle reference model
// predicts each cycle's bus view; an independent monitor compares mid-cycle.
module tb_cdp1802_dma_ctrl;
    import cdp1802_pkg::*;

    localparam int CL    = CYCLE_LEN_DEF;
    localparam int DT    = DATA_TICK_DEF;
    localparam int NRAND = 300;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        clk_enable = 1'b0;
    logic [1:0]  core_sc    = 2'b00;
    logic        DMAO       = 1'b0;
    logic        INT        = 1'b0;
    logic        ie_set     = 1'b0;
    logic        ie_clr     = 1'b0;
    logic        r0_wr      = 1'b0;
    logic [15:0] r0_wdata   = 16'h0000;
    logic        core_hold;
    logic        ie;
    logic [15:0] r0;
    logic [1:0]  SC;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [7:0]  data_out;
    logic        int_taken;
`ifdef CDP1802_DMA_IN_EN
    logic        DMAI        = 1'b0;
    logic [7:0]  dma_in_data = 8'h00;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
`endif

    cdp1802_dma_ctrl #(.CYCLE_LEN(CL), .DATA_TICK(DT)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .core_sc    (core_sc),
        .core_hold  (core_hold),
        .DMAO       (DMAO),
        .INT        (INT),
        .ie         (ie),
        .ie_set     (ie_set),
        .ie_clr     (ie_clr),
        .r0_wr      (r0_wr),
        .r0_wdata   (r0_wdata),
        .r0         (r0),
        .SC         (SC),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .data_out   (data_out),
        .int_taken  (int_taken)
`ifdef CDP1802_DMA_IN_EN
        ,
        .DMAI        (DMAI),
        .dma_in_data (dma_in_data),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'h3C;
    endfunction

    assign mem_data = mem_byte(mem_addr);

    typedef struct {
        logic [1:0]  sc;
        logic        hold;
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic [15:0] r0;
        logic        ie;
        int          itk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: one step per machine cycle; cycle type equals its SC code.
    int          m_cur;
    logic [15:0] m_r0;
    logic        m_ie;
    logic [7:0]  m_dout;

    task automatic push_record();
        exp_t e;
        e.sc   = 2'(m_cur);
        e.hold = (m_cur >= 2);
        e.rd   = (m_cur == 2);
        e.addr = m_r0;
        e.dout = m_dout;
        e.r0   = m_r0;
        e.ie   = m_ie;
        e.itk  = (m_cur == 3) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cur  = 0;
        m_r0   = 16'h0000;
        m_ie   = 1'b1;
        m_dout = 8'h00;
        push_record();
    endtask

    task automatic clear_inputs();
        core_sc = 2'b00; DMAO = 1'b0; INT = 1'b0;
        ie_set = 1'b0; ie_clr = 1'b0; r0_wr = 1'b0;
    endtask

    // One clk_enable tick, with random stall clocks in front of it.
    task automatic tick_edge();
        @(negedge clk);
        while ($urandom_range(0, 3) == 0) begin
            clk_enable = 1'b0;
            @(negedge clk);
        end
        clk_enable = 1'b1;
        @(posedge clk);
        #1;
        clk_enable = 1'b0;
    endtask

    task automatic run_cycle(input logic [1:0] sc_req, input bit dmao_v, input bit int_v,
                             input bit drop, input bit wr, input logic [15:0] wd,
                             input bit iset, input bit iclr, input bit iset0);
        bit   dm, it, set0;
        int   nxt;
        set0 = iset0 && (m_cur == 3);
        for (int i = 0; i < CL; i++) begin
            core_sc  = sc_req;
            DMAO     = dmao_v && !(drop && i == CL - 1);
            INT      = int_v && !(drop && i == CL - 1);
            r0_wr    = wr && (i == DT + 1);
            r0_wdata = wd;
            ie_set   = (iset && i == DT + 1) || (set0 && i == 0);
            ie_clr   = iclr && (i == DT + 1);
            tick_edge();
        end
        if (wr && m_cur <= 1) m_r0 = wd;
        if (iclr) m_ie = 1'b0;
        else if (iset) m_ie = 1'b1;
        if (m_cur == 2) m_r0 = m_r0 + 16'd1;
        dm = dmao_v && !drop;
        it = int_v && !drop;
        if (m_cur == 0) nxt = int'(sc_req);
        else if (dm) nxt = 2;
        else if (it && m_ie && m_cur != 3) nxt = 3;
        else if (m_cur == 3) nxt = 0;
        else nxt = int'(sc_req);
        m_cur = nxt;
        if (nxt == 3) m_ie = 1'b0;
        if (nxt == 2) m_dout = mem_byte(m_r0);
        push_record();
    endtask

    task automatic idle_cycle(input logic [1:0] sc_req);
        run_cycle(sc_req, 0, 0, 0, 0, 16'h0, 0, 0, 0);
    endtask

    task automatic goto_exec();
        while (m_cur != 1) idle_cycle(2'b01);
    endtask

    // Monitor: tracks the tick position itself and compares after the data tick.
    int   mon_cnt  = 0;
    bit   mon_done = 0;
    int   mon_itk  = 0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                mon_cnt = 0; mon_done = 0; mon_itk = 0;
            end else begin
                if (int_taken) mon_itk++;
                if (mon_cnt == DT + 1 && !mon_done) begin
                    mon_done = 1;
                    check("sb_nonempty", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        check("sc", SC, mon_e.sc);
                        check("core_hold", core_hold, mon_e.hold);
                        check("mem_rd", mem_rd, mon_e.rd);
                        if (mon_e.rd) check("mem_addr", mem_addr, mon_e.addr);
                        check("data_out", data_out, mon_e.dout);
                        check("r0", r0, mon_e.r0);
                        check("ie", ie, mon_e.ie);
                        check("int_taken_count", mon_itk, mon_e.itk);
                    end
                end
                if (clk_enable) begin
                    if (mon_cnt == CL - 1) begin
                        mon_cnt = 0; mon_done = 0; mon_itk = 0;
                    end else begin
                        mon_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [1:0]  rs;
        logic [15:0] rw;
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_sc", SC, SC_FETCH);
        check("rst_r0", r0, 16'h0000);
        check("rst_ie", ie, 1'b1);
        check("rst_hold", core_hold, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_data_out", data_out, 8'h00);
        check("rst_int_taken", int_taken, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) idle_cycle((i % 2 == 0) ? SC_EXEC : SC_FETCH);

        // Eight-byte display burst from 0x0100.
        goto_exec();
        run_cycle(SC_EXEC, 1, 0, 0, 1, 16'h0100, 0, 0, 0);
        for (int i = 0; i < 7; i++) run_cycle(SC_FETCH, 1, 0, 0, 0, 16'h0, 0, 0, 0);
        idle_cycle(SC_FETCH);
        check("burst_r0", r0, 16'h0108);

        // R0 wrap.
        goto_exec();
        run_cycle(SC_EXEC, 1, 0, 0, 1, 16'hFFFF, 0, 0, 0);
        idle_cycle(SC_FETCH);
        check("wrap_r0", r0, 16'h0000);
        check("wrap_data_out", data_out, mem_byte(16'hFFFF));

        // Request dropped before the boundary is not serviced.
        goto_exec();
        run_cycle(SC_EXEC, 1, 1, 1, 0, 16'h0, 0, 0, 0);

        // Interrupt, masked re-request, re-enable; tick-0 ie_set loses to entry clear.
        goto_exec();
        run_cycle(SC_EXEC, 0, 1, 0, 0, 16'h0, 0, 0, 0);
        run_cycle(SC_EXEC, 0, 1, 0, 0, 16'h0, 0, 0, 1);
        check("irq_ie_cleared", ie, 1'b0);
        run_cycle(SC_EXEC, 0, 1, 0, 0, 16'h0, 0, 0, 0);
        run_cycle(SC_EXEC, 0, 1, 0, 0, 16'h0, 0, 0, 0);
        run_cycle(SC_EXEC, 0, 1, 0, 0, 16'h0, 1, 0, 0);
        run_cycle(SC_FETCH, 0, 0, 0, 0, 16'h0, 0, 0, 1);

        // DMA and interrupt at the same boundary: S2 first, then S3.
        goto_exec();
        run_cycle(SC_EXEC, 1, 1, 0, 0, 16'h0, 1, 0, 0);
        run_cycle(SC_FETCH, 0, 1, 0, 0, 16'h0, 0, 0, 0);
        idle_cycle(SC_EXEC);

        // Reset three ticks into a DMA cycle.
        goto_exec();
        run_cycle(SC_EXEC, 1, 0, 0, 1, 16'h1234, 0, 0, 0);
        clear_inputs();
        repeat (3) tick_edge();
        reset = 1'b0;
        #1;
        check("midrst_sc", SC, SC_FETCH);
        check("midrst_mem_rd", mem_rd, 1'b0);
        check("midrst_r0", r0, 16'h0000);
        check("midrst_hold", core_hold, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < NRAND; n++) begin
            rs = 2'($urandom_range(0, 1));
            rw = 16'($urandom);
            run_cycle(rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), rw,
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(negedge clk);
        check("sb_drain", exp_q.size(), 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
